// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and writeback stage with dmem req/ack handshake and access timeout
// Optional feature macro: MISALIGN_TRAP_EN (adds misalign_exc, traps misaligned half/word accesses)
module mem_wb_stage #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_exc,
`endif
    output logic        mem_err
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {IDLE, MEM} state_t;

    state_t                 state, state_nx;
    logic [TIMEOUT_W-1:0]   cnt, cnt_nx;
    logic                   req_nx, we_nx, wb_en_nx, mem_err_nx;
    logic [3:0]             be_nx;
    logic [31:0]            addr_nx, wdata_nx, wb_data_nx;
    logic [4:0]             wb_rd_nx;
    logic [2:0]             ld_f3, ld_f3_nx;
    logic [1:0]             ld_off, ld_off_nx;
    logic [4:0]             ld_rd, ld_rd_nx;
    logic                   misalign_nx;

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [1:0]  eff_off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        misaligned;
    logic [31:0] ld_shifted;
    logic [31:0] ld_value;
    logic        unused_instr_bits;

    assign opc  = instruction_in[6:0];
    assign rd   = instruction_in[11:7];
    assign f3   = instruction_in[14:12];
    assign a    = alu_in[1:0];
    assign unused_instr_bits = ^instruction_in[31:15];

    assign in_ready = (state == IDLE);

    // Low address bits that cannot apply to the access size are dropped.
    always_comb begin
        eff_off    = 2'b00;
        st_be      = 4'b1111;
        st_wdata   = store_data;
        misaligned = 1'b0;
        case (f3[1:0])
            2'b00: begin
                eff_off  = a;
                st_be    = 4'b0001 << a;
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                eff_off    = {a[1], 1'b0};
                st_be      = 4'b0011 << {a[1], 1'b0};
                st_wdata   = {2{store_data[15:0]}};
                misaligned = a[0];
            end
            default: begin
                misaligned = (a != 2'b00);
            end
        endcase
    end

    assign ld_shifted = dmem_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_f3)
            3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_value = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_value = {16'd0, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        req_nx      = dmem_req;
        we_nx       = dmem_we;
        be_nx       = dmem_be;
        addr_nx     = dmem_addr;
        wdata_nx    = dmem_wdata;
        wb_en_nx    = 1'b0;
        wb_rd_nx    = wb_rd;
        wb_data_nx  = wb_data;
        mem_err_nx  = 1'b0;
        ld_f3_nx    = ld_f3;
        ld_off_nx   = ld_off;
        ld_rd_nx    = ld_rd;
        misalign_nx = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (opc == OPC_LOAD || opc == OPC_STORE) begin
`ifdef MISALIGN_TRAP_EN
                        if (misaligned) begin
                            misalign_nx = 1'b1;
                        end else begin
`else
                        begin
`endif
                            state_nx  = MEM;
                            cnt_nx    = '0;
                            req_nx    = 1'b1;
                            we_nx     = (opc == OPC_STORE);
                            be_nx     = (opc == OPC_STORE) ? st_be : 4'b1111;
                            addr_nx   = {alu_in[31:2], 2'b00};
                            wdata_nx  = (opc == OPC_STORE) ? st_wdata : dmem_wdata;
                            ld_f3_nx  = f3;
                            ld_off_nx = eff_off;
                            ld_rd_nx  = rd;
                        end
                    end else if (rd != 5'd0) begin
                        case (opc)
                            OPC_JAL, OPC_JALR: begin
                                wb_en_nx   = 1'b1;
                                wb_rd_nx   = rd;
                                wb_data_nx = pc + 32'd4;
                            end
                            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                                wb_en_nx   = 1'b1;
                                wb_rd_nx   = rd;
                                wb_data_nx = alu_in;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            MEM: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (dmem_ack) begin
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    if (!dmem_we && ld_rd != 5'd0) begin
                        wb_en_nx   = 1'b1;
                        wb_rd_nx   = ld_rd;
                        wb_data_nx = ld_value;
                    end
                end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                    state_nx   = IDLE;
                    req_nx     = 1'b0;
                    mem_err_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + TIMEOUT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            wb_en      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            mem_err    <= 1'b0;
            ld_f3      <= 3'd0;
            ld_off     <= 2'd0;
            ld_rd      <= 5'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dmem_req   <= req_nx;
            dmem_we    <= we_nx;
            dmem_be    <= be_nx;
            dmem_addr  <= addr_nx;
            dmem_wdata <= wdata_nx;
            wb_en      <= wb_en_nx;
            wb_rd      <= wb_rd_nx;
            wb_data    <= wb_data_nx;
            mem_err    <= mem_err_nx;
            ld_f3      <= ld_f3_nx;
            ld_off     <= ld_off_nx;
            ld_rd      <= ld_rd_nx;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_exc <= 1'b0;
        else     misalign_exc <= misalign_nx;
    end
`else
    logic unused_misalign;
    assign unused_misalign = misalign_nx ^ misaligned;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction_in = 32'd0;
    logic [31:0] alu_in = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_in(instruction_in), .alu_in(alu_in),
        .store_data(store_data), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {17'd0, f3, rd, opc};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2);
        in_valid       = 1'b1;
        instruction_in = ins;
        alu_in         = alu;
        store_data     = rs2;
        step();
        in_valid       = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_err", mem_err, 0);
        rst = 1'b0;
        step();

        // ADDI then JAL back-to-back
        in_valid = 1'b1; instruction_in = mk(3'b000, 5'd5, 7'b0010011); alu_in = 32'h1234;
        step();
        chk("addi_wb_en", wb_en, 1);
        chk("addi_wb_rd", wb_rd, 5);
        chk("addi_wb_data", wb_data, 32'h00001234);
        chk("addi_in_ready", in_ready, 1);
        instruction_in = mk(3'b000, 5'd1, 7'b1101111); pc = 32'h100; alu_in = 32'h5555;
        step();
        chk("jal_wb_en", wb_en, 1);
        chk("jal_wb_rd", wb_rd, 1);
        chk("jal_wb_data", wb_data, 32'h104);
        instruction_in = mk(3'b000, 5'd0, 7'b1101111);
        step();
        chk("jal_rd0_wb_en", wb_en, 0);
        instruction_in = mk(3'b000, 5'd31, 7'b0110111); alu_in = 32'hDEAD0000;
        step();
        chk("lui_wb_rd", wb_rd, 31);
        chk("lui_wb_data", wb_data, 32'hDEAD0000);
        instruction_in = mk(3'b000, 5'd4, 7'b1100011);
        step();
        chk("branch_wb_en", wb_en, 0);
        in_valid = 1'b0;
        step();
        chk("idle_wb_en", wb_en, 0);

        // LB a=0x1003, ack in third request cycle
        issue(mk(3'b000, 5'd7, 7'b0000011), 32'h1003, 32'd0);
        chk("lb_req_c1", dmem_req, 1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_be", dmem_be, 4'b1111);
        chk("lb_we", dmem_we, 0);
        chk("lb_ready_c1", in_ready, 0);
        step();
        chk("lb_req_c2", dmem_req, 1);
        chk("lb_ready_c2", in_ready, 0);
        step();
        chk("lb_req_c3", dmem_req, 1);
        chk("lb_ready_c3", in_ready, 0);
        chk("lb_wb_en_c3", wb_en, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
        step();
        dmem_ack = 1'b0;
        chk("lb_req_done", dmem_req, 0);
        chk("lb_wb_en", wb_en, 1);
        chk("lb_wb_rd", wb_rd, 7);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        chk("lb_ready_done", in_ready, 1);
        step();
        chk("lb_wb_en_pulse", wb_en, 0);

        // LBU same address, immediate ack
        issue(mk(3'b100, 5'd8, 7'b0000011), 32'h1003, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
        step();
        dmem_ack = 1'b0;
        chk("lbu_wb_data", wb_data, 32'h00000080);
        chk("lbu_wb_rd", wb_rd, 8);

        // LH a=0x4003: forced to upper half, sign extended
        issue(mk(3'b001, 5'd9, 7'b0000011), 32'h4003, 32'd0);
        chk("lh_addr", dmem_addr, 32'h4000);
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_7FFF;
        step();
        dmem_ack = 1'b0;
        chk("lh_wb_data", wb_data, 32'hFFFF8001);

        // SH a=0x2002
        issue(mk(3'b001, 5'd3, 7'b0100011), 32'h2002, 32'hABCD1234);
        chk("sh_req", dmem_req, 1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'h12341234);
        chk("sh_we", dmem_we, 1);
        chk("sh_addr", dmem_addr, 32'h2000);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sh_wb_en", wb_en, 0);
        chk("sh_req_done", dmem_req, 0);
        chk("sh_ready", in_ready, 1);

        // SB a=0x2001
        issue(mk(3'b000, 5'd3, 7'b0100011), 32'h2001, 32'h000000AB);
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sb_wb_en", wb_en, 0);

        // LW with ack withheld: four request cycles, then mem_err
        issue(mk(3'b010, 5'd10, 7'b0000011), 32'h3000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_c%0d", i), dmem_req, 1);
            chk($sformatf("to_err_c%0d", i), mem_err, 0);
            step();
        end
        chk("to_mem_err", mem_err, 1);
        chk("to_req_done", dmem_req, 0);
        chk("to_wb_en", wb_en, 0);
        chk("to_ready", in_ready, 1);
        step();
        chk("to_mem_err_pulse", mem_err, 0);

        // Ack on the timeout cycle completes normally
        issue(mk(3'b010, 5'd11, 7'b0000011), 32'h3004, 32'd0);
        step(); step(); step();
        chk("toack_req_c4", dmem_req, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
        step();
        dmem_ack = 1'b0;
        chk("toack_mem_err", mem_err, 0);
        chk("toack_wb_en", wb_en, 1);
        chk("toack_wb_data", wb_data, 32'h11223344);

        // Ack in IDLE is ignored
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_wb_en", wb_en, 0);
        chk("idle_ack_req", dmem_req, 0);

        // Reset asserted in second MEM cycle
        issue(mk(3'b010, 5'd12, 7'b0000011), 32'h5000, 32'd0);
        step();
        chk("rstmid_req_before", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_req_async", dmem_req, 0);
        chk("rstmid_ready", in_ready, 1);
        step();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rstmid_wb_en_%0d", i), wb_en, 0);
            chk($sformatf("rstmid_mem_err_%0d", i), mem_err, 0);
            step();
        end
        chk("rstmid_ready_end", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
